// File: rtl/ctrl_pipe.sv
// Control-word pipeline for the 5-stage CPU: stages decoder fields through ID/EX, EX/MEM, MEM/WB
// and detects RAW hazards. Define CTRL_PIPE_FORWARD_EN to enable EX operand forwarding.
`timescale 1ns/1ps
module ctrl_pipe #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_RegDst_o,
  output logic              ex_ALUSrc_o,
  output logic [1:0]        ex_ALUOp_o,
  output logic              mem_MemWrite_o,
  output logic              mem_MemRead_o,
  output logic              wb_RegWrite_o,
  output logic              wb_MemtoReg_o,
  output logic [REG_W-1:0]  mem_wreg_o,
  output logic [REG_W-1:0]  wb_wreg_o,
  output logic [1:0]        fwdA_o,
  output logic [1:0]        fwdB_o
);

  localparam int unsigned BitRegDst   = 9;
  localparam int unsigned BitAluSrc   = 8;
  localparam int unsigned BitMemtoReg = 7;
  localparam int unsigned BitRegWrite = 6;
  localparam int unsigned BitMemWrite = 5;
  localparam int unsigned BitMemRead  = 4;

  logic             ex_regdst_q, ex_alusrc_q, ex_memtoreg_q, ex_regwrite_q;
  logic             ex_memwrite_q, ex_memread_q;
  logic [1:0]       ex_aluop_q;
  logic [REG_W-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic             mem_memtoreg_q, mem_regwrite_q, mem_memwrite_q, mem_memread_q;
  logic [REG_W-1:0] mem_wreg_q;
  logic             wb_regwrite_q, wb_memtoreg_q;
  logic [REG_W-1:0] wb_wreg_q;

  logic [REG_W-1:0] ex_wreg;
  logic             load_use;
  logic             bubble;

  // Branch/Jump resolve in ID and are never staged.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_i[3:2];

  assign ex_wreg  = ex_regdst_q ? ex_rd_q : ex_rt_q;
  assign load_use = ex_memread_q && (ex_rt_q != '0) && ((ex_rt_q == rs_i) || (ex_rt_q == rt_i));
  assign bubble   = flush_i | stall_o;

`ifdef CTRL_PIPE_FORWARD_EN
  always_comb begin
    fwdA_o = 2'b00;
    fwdB_o = 2'b00;
    if (mem_regwrite_q && (mem_wreg_q != '0) && (mem_wreg_q == ex_rs_q)) begin
      fwdA_o = 2'b10;
    end else if (wb_regwrite_q && (wb_wreg_q != '0) && (wb_wreg_q == ex_rs_q)) begin
      fwdA_o = 2'b01;
    end
    if (mem_regwrite_q && (mem_wreg_q != '0) && (mem_wreg_q == ex_rt_q)) begin
      fwdB_o = 2'b10;
    end else if (wb_regwrite_q && (wb_wreg_q != '0) && (wb_wreg_q == ex_rt_q)) begin
      fwdB_o = 2'b01;
    end
  end

  assign stall_o = load_use;
`else
  logic ex_hit, mem_hit;
  logic unused_ex_rs;

  assign fwdA_o       = 2'b00;
  assign fwdB_o       = 2'b00;
  assign unused_ex_rs = ^ex_rs_q;

  // Without forwarding, hold the consumer until the producer reaches MEM/WB.
  assign ex_hit  = ex_regwrite_q && (ex_wreg != '0) &&
                   (((rs_i != '0) && (rs_i == ex_wreg)) || ((rt_i != '0) && (rt_i == ex_wreg)));
  assign mem_hit = mem_regwrite_q && (mem_wreg_q != '0) &&
                   (((rs_i != '0) && (rs_i == mem_wreg_q)) ||
                    ((rt_i != '0) && (rt_i == mem_wreg_q)));
  assign stall_o = load_use | ex_hit | mem_hit;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_regdst_q    <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_aluop_q     <= 2'b00;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_wreg_q     <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_wreg_q      <= '0;
    end else begin
      ex_regdst_q    <= bubble ? 1'b0 : ctrl_i[BitRegDst];
      ex_alusrc_q    <= bubble ? 1'b0 : ctrl_i[BitAluSrc];
      ex_memtoreg_q  <= bubble ? 1'b0 : ctrl_i[BitMemtoReg];
      ex_regwrite_q  <= bubble ? 1'b0 : ctrl_i[BitRegWrite];
      ex_memwrite_q  <= bubble ? 1'b0 : ctrl_i[BitMemWrite];
      ex_memread_q   <= bubble ? 1'b0 : ctrl_i[BitMemRead];
      ex_aluop_q     <= bubble ? 2'b00 : ctrl_i[1:0];
      ex_rs_q        <= rs_i;
      ex_rt_q        <= rt_i;
      ex_rd_q        <= rd_i;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_memread_q  <= ex_memread_q;
      mem_wreg_q     <= ex_wreg;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_wreg_q      <= mem_wreg_q;
    end
  end

  assign ex_RegDst_o    = ex_regdst_q;
  assign ex_ALUSrc_o    = ex_alusrc_q;
  assign ex_ALUOp_o     = ex_aluop_q;
  assign mem_MemWrite_o = mem_memwrite_q;
  assign mem_MemRead_o  = mem_memread_q;
  assign mem_wreg_o     = mem_wreg_q;
  assign wb_RegWrite_o  = wb_regwrite_q;
  assign wb_MemtoReg_o  = wb_memtoreg_q;
  assign wb_wreg_o      = wb_wreg_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed instruction rows with hand-derived stall/forward
// values; captured control words are queued and checked as they appear at EX, MEM and WB.
`timescale 1ns/1ps
module tb_ctrl_pipe;

  localparam logic [9:0] AddW = 10'b1001000010;
  localparam logic [9:0] LwW  = 10'b0111010000;
  localparam logic [9:0] SwW  = 10'b1110100000;
  localparam logic [9:0] NopW = 10'b0000000000;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [9:0] ctrl_i;
  logic [4:0] rs_i, rt_i, rd_i;
  logic       flush_i;
  logic       stall_o;
  logic       ex_RegDst_o, ex_ALUSrc_o;
  logic [1:0] ex_ALUOp_o;
  logic       mem_MemWrite_o, mem_MemRead_o, wb_RegWrite_o, wb_MemtoReg_o;
  logic [4:0] mem_wreg_o, wb_wreg_o;
  logic [1:0] fwdA_o, fwdB_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         in_rst;
    bit         flush;
    logic [9:0] ctrl;
    logic [4:0] rd, rs, rt;
    bit         stall;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct packed {
    logic       rst;
    logic [9:0] ctrl;
    logic [4:0] wreg;
  } ent_t;

  vec_t vecs[$];
  ent_t ex_q[$];

  ctrl_pipe #(.REG_W(5), .CTRL_W(10)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ctrl_i         (ctrl_i),
    .rs_i           (rs_i),
    .rt_i           (rt_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .ex_RegDst_o    (ex_RegDst_o),
    .ex_ALUSrc_o    (ex_ALUSrc_o),
    .ex_ALUOp_o     (ex_ALUOp_o),
    .mem_MemWrite_o (mem_MemWrite_o),
    .mem_MemRead_o  (mem_MemRead_o),
    .wb_RegWrite_o  (wb_RegWrite_o),
    .wb_MemtoReg_o  (wb_MemtoReg_o),
    .mem_wreg_o     (mem_wreg_o),
    .wb_wreg_o      (wb_wreg_o),
    .fwdA_o         (fwdA_o),
    .fwdB_o         (fwdB_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int row, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
    end
  endtask

  task automatic r(input bit in_rst, input bit flush, input logic [9:0] ctrl, input int rd,
                   input int rs, input int rt, input bit stall, input int fa, input int fb);
    vec_t v;
    v.in_rst = in_rst;
    v.flush  = flush;
    v.ctrl   = ctrl;
    v.rd     = rd[4:0];
    v.rs     = rs[4:0];
    v.rt     = rt[4:0];
    v.stall  = stall;
    v.fa     = fa[1:0];
    v.fb     = fb[1:0];
    vecs.push_back(v);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) r(0, 0, NopW, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic build_table();
    r(1, 0, AddW, 1, 2, 3, 0, 0, 0);
    r(1, 0, AddW, 1, 2, 3, 0, 0, 0);
`ifdef CTRL_PIPE_FORWARD_EN
    r(0, 0, AddW, 1, 2, 3, 0, 0, 0);
    nops(3);
    r(0, 0, LwW,  0, 1, 2, 0, 0, 0);
    r(0, 0, AddW, 3, 2, 4, 1, 0, 0);  // load-use: one bubble
    r(0, 0, AddW, 3, 2, 4, 0, 2, 0);
    r(0, 0, NopW, 0, 0, 0, 0, 1, 0);  // loaded value now in WB
    nops(1);
    r(0, 0, AddW, 5, 1, 1, 0, 0, 0);
    r(0, 0, AddW, 6, 5, 5, 0, 0, 0);
    r(0, 0, NopW, 0, 0, 0, 0, 2, 2);
    r(0, 0, AddW, 10, 1, 1, 0, 0, 0);
    nops(1);
    r(0, 0, AddW, 6, 10, 10, 0, 0, 0);
    r(0, 0, NopW, 0, 0, 0, 0, 1, 1);
    r(0, 0, AddW, 11, 1, 1, 0, 0, 0);
    r(0, 0, AddW, 11, 2, 2, 0, 0, 0);
    r(0, 0, AddW, 12, 11, 1, 0, 0, 0);
    r(0, 0, NopW, 0, 0, 0, 0, 2, 0);  // EX/MEM wins over MEM/WB
    r(0, 0, AddW, 0, 1, 2, 0, 0, 0);
    r(0, 0, AddW, 8, 0, 0, 0, 0, 0);
    nops(1);
    r(0, 1, LwW,  0, 1, 9, 0, 0, 0);
    r(0, 0, AddW, 3, 9, 9, 0, 0, 0);
    r(0, 0, SwW,  9, 1, 4, 0, 0, 0);
    r(0, 0, AddW, 1, 4, 9, 0, 0, 0);
    nops(1);
`else
    r(0, 0, AddW, 1, 2, 3, 0, 0, 0);
    nops(3);
    r(0, 0, LwW,  0, 1, 2, 0, 0, 0);
    r(0, 0, AddW, 3, 2, 4, 1, 0, 0);
    r(0, 0, AddW, 3, 2, 4, 1, 0, 0);
    r(0, 0, AddW, 3, 2, 4, 0, 0, 0);
    nops(3);
    r(0, 0, AddW, 5, 1, 1, 0, 0, 0);
    r(0, 0, AddW, 7, 5, 1, 1, 0, 0);
    r(0, 0, AddW, 7, 5, 1, 1, 0, 0);
    r(0, 0, AddW, 7, 5, 1, 0, 0, 0);
    r(0, 0, AddW, 0, 1, 2, 0, 0, 0);
    r(0, 0, AddW, 8, 0, 0, 0, 0, 0);  // $0 never a hazard
    nops(1);
    r(0, 1, LwW,  0, 1, 9, 0, 0, 0);
    nops(1);
    r(0, 0, SwW,  9, 1, 4, 0, 0, 0);
    r(0, 0, AddW, 1, 4, 9, 0, 0, 0);  // store writes nothing: no stall
    nops(1);
`endif
    r(1, 0, AddW, 1, 2, 3, 0, 0, 0);  // mid-run reset discards in-flight control
    nops(3);
  endtask

  // Driver: applies rows, checks stall/forward, queues what ID/EX should capture.
  initial begin
    ent_t ent;
    bit   bub;
    rst_i   = 1'b0;
    ctrl_i  = '0;
    rs_i    = '0;
    rt_i    = '0;
    rd_i    = '0;
    flush_i = 1'b0;
    build_table();
    @(posedge clk_i);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_i   = ~vecs[i].in_rst;
      flush_i = vecs[i].flush;
      ctrl_i  = vecs[i].ctrl;
      rs_i    = vecs[i].rs;
      rt_i    = vecs[i].rt;
      rd_i    = vecs[i].rd;
      @(negedge clk_i);
      check("stall", i, {15'd0, stall_o}, {15'd0, vecs[i].stall});
      check("fwd", i, {12'd0, fwdA_o, fwdB_o}, {12'd0, vecs[i].fa, vecs[i].fb});
      bub      = vecs[i].in_rst | vecs[i].flush | vecs[i].stall;
      ent.rst  = vecs[i].in_rst;
      ent.ctrl = bub ? 10'd0 : vecs[i].ctrl;
      ent.wreg = vecs[i].in_rst ? 5'd0 : (ent.ctrl[9] ? vecs[i].rd : vecs[i].rt);
      @(posedge clk_i);
      ex_q.push_back(ent);
      #1;
    end
    @(negedge clk_i);
    #1;
    check("drain", 0, 16'(ex_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: each cycle the newest capture sits in EX, older ones in MEM and WB.
  initial begin
    ent_t e, p1, p2;
    int   cyc;
    p1  = '0;
    p2  = '0;
    cyc = 0;
    forever begin
      @(negedge clk_i);
      if (ex_q.size() > 0) begin
        e = ex_q.pop_front();
        if (e.rst) begin
          p1 = '0;
          p2 = '0;
        end
        check("ex", cyc, {12'd0, ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o},
              {12'd0, e.ctrl[9], e.ctrl[8], e.ctrl[1:0]});
        check("mem", cyc, {9'd0, mem_MemWrite_o, mem_MemRead_o, mem_wreg_o},
              {9'd0, p1.ctrl[5], p1.ctrl[4], p1.wreg});
        check("wb", cyc, {9'd0, wb_RegWrite_o, wb_MemtoReg_o, wb_wreg_o},
              {9'd0, p2.ctrl[6], p2.ctrl[7], p2.wreg});
        p2 = p1;
        p1 = e;
        cyc++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
